// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer and the immediate generator.
// The immediate generator uses the same IMM_* values carried on imm_sel.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_IALU   = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] IMM_I    = 2'd0;
    localparam logic [1:0] IMM_S    = 2'd1;
    localparam logic [1:0] IMM_B    = 2'd2;
    localparam logic [1:0] IMM_NONE = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] TC_NONE    = 2'd0;
    localparam logic [1:0] TC_ILLEGAL = 2'd1;
    localparam logic [1:0] TC_IMEM_TO = 2'd2;
    localparam logic [1:0] TC_DMEM_TO = 2'd3;

    typedef struct packed {
        cls_t       cls;
        logic [1:0] imm_sel;
        logic       legal;
    } dec_t;

    function automatic dec_t decode_opcode(input logic [6:0] op);
        dec_t d;
        d.legal = 1'b1;
        case (op)
            OP_R:      begin d.cls = CLS_R;      d.imm_sel = IMM_NONE; end
            OP_IALU:   begin d.cls = CLS_IALU;   d.imm_sel = IMM_I;    end
            OP_LOAD:   begin d.cls = CLS_LOAD;   d.imm_sel = IMM_I;    end
            OP_STORE:  begin d.cls = CLS_STORE;  d.imm_sel = IMM_S;    end
            OP_BRANCH: begin d.cls = CLS_BRANCH; d.imm_sel = IMM_B;    end
            default:   begin d.cls = CLS_NONE;   d.imm_sel = IMM_NONE; d.legal = 1'b0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait counter shared by FETCH and MEM; o_timeout flags the last
// permitted not-ready cycle so the FSM can trap on that same cycle.
module ctrl_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_timeout
);

    localparam logic [7:0] TC = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_timeout = (r_cnt == TC);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV64 core.
// Define CTRL_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
//
// state  | meaning
// IDLE   | one cycle after reset, then fetch
// FETCH  | imem_req high, wait for imem_ready (timeout -> TRAP cause 2)
// DECODE | classify opcode, latch class and imm_sel (illegal -> TRAP cause 1)
// EXEC   | ALU cycle; branches resolve here and return to FETCH
// MEM    | load/store held until dmem_ready (timeout -> TRAP cause 3)
// WB     | register-file write and PC+4 update
// TRAP   | absorbing; only reset_n leaves
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      instruction,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             alu_zero,
    output logic             ir_load,
    output logic [1:0]       imm_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             trap,
    output logic [1:0]       trap_cause
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_t     r_state;
    state_t     w_state_next;
    cls_t       r_cls;
    logic [1:0] r_imm_sel;
    logic [1:0] r_trap_cause;
    logic [1:0] w_trap_cause_next;
    logic [6:0] r_opcode;
    logic [2:0] r_funct3;
    dec_t       w_dec;
    logic       w_timeout;
    logic       w_wait_inc;
    logic       w_br_legal;
    logic       w_br_taken;
    logic       w_instret;
    logic       w_unused_instr;

    assign w_unused_instr = ^{instruction[31:15], instruction[11:7]};

    assign w_dec      = decode_opcode(r_opcode);
    assign w_br_legal = (r_funct3 == F3_BEQ) || (r_funct3 == F3_BNE);
    assign w_br_taken = ((r_funct3 == F3_BEQ) &&  alu_zero) ||
                        ((r_funct3 == F3_BNE) && !alu_zero);
    assign w_wait_inc = ((r_state == ST_FETCH) && !imem_ready) ||
                        ((r_state == ST_MEM)   && !dmem_ready);

    ctrl_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clr     (w_state_next != r_state),
        .i_inc     (w_wait_inc),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cls        <= CLS_NONE;
            r_imm_sel    <= IMM_I;
            r_trap_cause <= TC_NONE;
            r_opcode     <= 7'd0;
            r_funct3     <= 3'd0;
        end else begin
            r_state      <= w_state_next;
            r_trap_cause <= w_trap_cause_next;
            if (ir_load) begin
                r_opcode <= instruction[6:0];
                r_funct3 <= instruction[14:12];
            end
            if (r_state == ST_DECODE) begin
                r_cls     <= w_dec.cls;
                r_imm_sel <= w_dec.imm_sel;
            end
        end
    end

    // Ready is checked before the timeout so a completion on the last allowed cycle wins.
    always_comb begin
        w_state_next      = r_state;
        w_trap_cause_next = r_trap_cause;
        case (r_state)
            ST_IDLE: w_state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    w_state_next = ST_DECODE;
                end else if (w_timeout) begin
                    w_state_next      = ST_TRAP;
                    w_trap_cause_next = TC_IMEM_TO;
                end
            end
            ST_DECODE: begin
                if (w_dec.legal) begin
                    w_state_next = ST_EXEC;
                end else begin
                    w_state_next      = ST_TRAP;
                    w_trap_cause_next = TC_ILLEGAL;
                end
            end
            ST_EXEC: begin
                case (r_cls)
                    CLS_R, CLS_IALU:     w_state_next = ST_WB;
                    CLS_LOAD, CLS_STORE: w_state_next = ST_MEM;
                    CLS_BRANCH: begin
                        if (w_br_legal) begin
                            w_state_next = ST_FETCH;
                        end else begin
                            w_state_next      = ST_TRAP;
                            w_trap_cause_next = TC_ILLEGAL;
                        end
                    end
                    default: begin
                        w_state_next      = ST_TRAP;
                        w_trap_cause_next = TC_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    w_state_next = (r_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (w_timeout) begin
                    w_state_next      = ST_TRAP;
                    w_trap_cause_next = TC_DMEM_TO;
                end
            end
            ST_WB:   w_state_next = ST_FETCH;
            ST_TRAP: w_state_next = ST_TRAP;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        trap       = 1'b0;
        imm_sel    = r_imm_sel;
        trap_cause = r_trap_cause;
        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
            end
            ST_EXEC: begin
                alu_src = (r_cls == CLS_IALU) || (r_cls == CLS_LOAD) || (r_cls == CLS_STORE);
                case (r_cls)
                    CLS_R, CLS_IALU: alu_op = ALU_FUNCT;
                    CLS_BRANCH:      alu_op = ALU_SUB;
                    default:         alu_op = ALU_ADD;
                endcase
                if (r_cls == CLS_BRANCH) begin
                    pc_write = w_br_legal;
                    pc_src   = w_br_legal && w_br_taken;
                end
            end
            ST_MEM: begin
                mem_read  = (r_cls == CLS_LOAD);
                mem_write = (r_cls == CLS_STORE);
                pc_write  = (r_cls == CLS_STORE) && dmem_ready;
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            ST_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign w_instret = ((r_state == ST_EXEC) && (r_cls == CLS_BRANCH) && w_br_legal) ||
                       ((r_state == ST_MEM)  && (r_cls == CLS_STORE)  && dmem_ready) ||
                       (r_state == ST_WB);

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if ((r_state != ST_IDLE) && (r_state != ST_TRAP)) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (w_instret) begin
                r_instret_cnt <= r_instret_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_instret | (CNT_W == 0);
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed-vector bench for multicycle_ctrl_fsm; expected output words are hand-built per cycle.
module tb_multicycle_ctrl_fsm;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADDI = 32'h00A08093;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_LW   = 32'h00012083;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    logic        clk;
    logic        reset_n;
    logic [31:0] instruction;
    logic        imem_req, imem_ready, dmem_ready, alu_zero, ir_load;
    logic [1:0]  imm_sel, alu_op, trap_cause;
    logic        alu_src, mem_read, mem_write, reg_write, pc_write, pc_src, trap;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int n_vec;
    int n_err;

    multicycle_ctrl_fsm #(
        .MEM_TIMEOUT (16),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instruction (instruction),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .alu_zero    (alu_zero),
        .ir_load     (ir_load),
        .imm_sel     (imm_sel),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .trap        (trap),
        .trap_cause  (trap_cause)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {imem_req, ir_load, imm_sel, alu_src, alu_op, mem_read, mem_write, reg_write, pc_write, pc_src, trap, trap_cause}
    function automatic logic [14:0] mk(logic req, logic irl, logic [1:0] imm, logic src, logic [1:0] aop,
                                       logic mr, logic mw, logic rw, logic pw, logic ps, logic tr, logic [1:0] tc);
        return {req, irl, imm, src, aop, mr, mw, rw, pw, ps, tr, tc};
    endfunction

    function automatic logic [14:0] e_f(logic [1:0] imm, logic irl);
        return mk(1, irl, imm, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    endfunction
    function automatic logic [14:0] e_d(logic [1:0] imm);
        return mk(0, 0, imm, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    endfunction
    function automatic logic [14:0] e_ex(logic [1:0] imm, logic src, logic [1:0] aop, logic pw, logic ps);
        return mk(0, 0, imm, src, aop, 0, 0, 0, pw, ps, 0, 2'd0);
    endfunction
    function automatic logic [14:0] e_m(logic [1:0] imm, logic mr, logic mw, logic pw);
        return mk(0, 0, imm, 0, 2'd0, mr, mw, 0, pw, 0, 0, 2'd0);
    endfunction
    function automatic logic [14:0] e_wb(logic [1:0] imm);
        return mk(0, 0, imm, 0, 2'd0, 0, 0, 1, 1, 0, 0, 2'd0);
    endfunction
    function automatic logic [14:0] e_trap(logic [1:0] imm, logic [1:0] tc);
        return mk(0, 0, imm, 0, 2'd0, 0, 0, 0, 0, 0, 1, tc);
    endfunction

    function automatic logic [14:0] outs();
        return {imem_req, ir_load, imm_sel, alu_src, alu_op, mem_read, mem_write,
                reg_write, pc_write, pc_src, trap, trap_cause};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge: drive, check at the falling edge, advance one cycle.
    task automatic cyc(input string tag, input logic ir, input logic [31:0] ins,
                       input logic dr, input logic az, input logic [14:0] exp);
        imem_ready  = ir;
        instruction = ins;
        dmem_ready  = dr;
        alu_zero    = az;
        @(negedge clk);
        chk(tag, {17'd0, outs()}, {17'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 chk(tag, {17'd0, outs()}, 32'd0);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        alu_zero   = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        instruction = 32'd0;
        imem_ready  = 1'b0;
        dmem_ready  = 1'b0;
        alu_zero    = 1'b0;
        @(negedge clk);
        chk("reset_outs", {17'd0, outs()}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // ADD then ADDI, zero-wait; ready seen in DECODE must be ignored
        cyc("idle",     0, 32'd0,  0, 0, e_d(2'd0));
        cyc("add_f",    1, I_ADD,  0, 0, e_f(2'd0, 1));
        cyc("add_d",    1, 32'd0,  1, 0, e_d(2'd0));
        cyc("add_e",    0, 32'd0,  0, 1, e_ex(2'd3, 0, 2'd2, 0, 0));
        cyc("add_w",    0, 32'd0,  0, 0, e_wb(2'd3));
        cyc("addi_f",   1, I_ADDI, 0, 0, e_f(2'd3, 1));
        cyc("addi_d",   0, 32'd0,  0, 0, e_d(2'd3));
        cyc("addi_e",   0, 32'd0,  0, 0, e_ex(2'd0, 1, 2'd2, 0, 0));
        cyc("addi_w",   0, 32'd0,  0, 0, e_wb(2'd0));

        // STORE zero-wait: completes in MEM with pc_write
        cyc("sw_f",     1, I_SW,   0, 0, e_f(2'd0, 1));
        cyc("sw_d",     0, 32'd0,  0, 0, e_d(2'd0));
        cyc("sw_e",     0, 32'd0,  0, 0, e_ex(2'd1, 1, 2'd0, 0, 0));
        cyc("sw_m",     0, 32'd0,  1, 0, e_m(2'd1, 0, 1, 1));

        // LOAD with dmem_ready delayed 3 cycles: mem_read for 4 cycles, then WB
        cyc("lw_f",     1, I_LW,   0, 0, e_f(2'd1, 1));
        cyc("lw_d",     0, 32'd0,  0, 0, e_d(2'd1));
        cyc("lw_e",     0, 32'd0,  0, 0, e_ex(2'd0, 1, 2'd0, 0, 0));
        cyc("lw_m1",    0, 32'd0,  0, 0, e_m(2'd0, 1, 0, 0));
        cyc("lw_m2",    0, 32'd0,  0, 0, e_m(2'd0, 1, 0, 0));
        cyc("lw_m3",    0, 32'd0,  0, 0, e_m(2'd0, 1, 0, 0));
        cyc("lw_m4",    0, 32'd0,  1, 0, e_m(2'd0, 1, 0, 0));
        cyc("lw_w",     0, 32'd0,  0, 0, e_wb(2'd0));

        // Branches
        cyc("beq1_f",   1, I_BEQ,  0, 0, e_f(2'd0, 1));
        cyc("beq1_d",   0, 32'd0,  0, 0, e_d(2'd0));
        cyc("beq1_e",   0, 32'd0,  0, 1, e_ex(2'd2, 0, 2'd1, 1, 1));
        cyc("beq0_f",   1, I_BEQ,  0, 0, e_f(2'd2, 1));
        cyc("beq0_d",   0, 32'd0,  0, 0, e_d(2'd2));
        cyc("beq0_e",   0, 32'd0,  0, 0, e_ex(2'd2, 0, 2'd1, 1, 0));
        cyc("bne0_f",   1, I_BNE,  0, 0, e_f(2'd2, 1));
        cyc("bne0_d",   0, 32'd0,  0, 0, e_d(2'd2));
        cyc("bne0_e",   0, 32'd0,  0, 0, e_ex(2'd2, 0, 2'd1, 1, 1));
        cyc("bne1_f",   1, I_BNE,  0, 0, e_f(2'd2, 1));
        cyc("bne1_d",   0, 32'd0,  0, 0, e_d(2'd2));
        cyc("bne1_e",   0, 32'd0,  0, 1, e_ex(2'd2, 0, 2'd1, 1, 0));

        // imem stalls 15 cycles, ready on the 16th (timeout cycle): ready wins
        for (int i = 0; i < 15; i++) cyc("fetch_stall", 0, 32'd0, 0, 0, e_f(2'd2, 0));
        cyc("fetch_ready16", 1, I_ADD, 0, 0, e_f(2'd2, 1));
        cyc("late_add_d", 0, 32'd0, 0, 0, e_d(2'd2));
        cyc("late_add_e", 0, 32'd0, 0, 0, e_ex(2'd3, 0, 2'd2, 0, 0));
        cyc("late_add_w", 0, 32'd0, 0, 0, e_wb(2'd3));

        // imem never ready: 16 FETCH cycles then TRAP cause 2
        for (int i = 0; i < 16; i++) cyc("fetch_wait", 0, 32'd0, 0, 0, e_f(2'd3, 0));
        for (int i = 0; i < 3; i++) cyc("imem_trap", 0, 32'd0, 0, 0, e_trap(2'd3, 2'd2));
        async_reset("rst_imem_trap");

        // Illegal opcode, then 20 cycles of stimulus with no enables
        cyc("ill_idle", 0, 32'd0, 0, 0, e_d(2'd0));
        cyc("ill_f",    1, I_ILL, 0, 0, e_f(2'd0, 1));
        cyc("ill_d",    0, 32'd0, 0, 0, e_d(2'd0));
        for (int i = 0; i < 20; i++) cyc("ill_trap_hold", 1, I_ADD, 1, 1, e_trap(2'd3, 2'd1));
        async_reset("rst_mid_trap");

        // dmem never ready on a LOAD: 16 MEM cycles then TRAP cause 3
        cyc("dto_idle", 0, 32'd0, 0, 0, e_d(2'd0));
        cyc("dto_f",    1, I_LW,  0, 0, e_f(2'd0, 1));
        cyc("dto_d",    0, 32'd0, 0, 0, e_d(2'd0));
        cyc("dto_e",    0, 32'd0, 0, 0, e_ex(2'd0, 1, 2'd0, 0, 0));
        for (int i = 0; i < 16; i++) cyc("dto_mem", 0, 32'd0, 0, 0, e_m(2'd0, 1, 0, 0));
        cyc("dmem_trap", 0, 32'd0, 1, 0, e_trap(2'd0, 2'd3));
        async_reset("rst_dmem_trap");

        // Reset asserted in the middle of a MEM store
        cyc("rs_idle", 0, 32'd0, 0, 0, e_d(2'd0));
        cyc("rs_f",    1, I_SW,  0, 0, e_f(2'd0, 1));
        cyc("rs_d",    0, 32'd0, 0, 0, e_d(2'd0));
        cyc("rs_e",    0, 32'd0, 0, 0, e_ex(2'd1, 1, 2'd0, 0, 0));
        #2 chk("st_mem_pending", {17'd0, outs()}, {17'd0, e_m(2'd1, 0, 1, 0)});
        async_reset("rst_mid_store");

        // Restart from IDLE with three zero-wait ADDs
        cyc("re_idle", 0, 32'd0, 0, 0, e_d(2'd0));
        for (int k = 0; k < 3; k++) begin
            cyc("re_add_f", 1, I_ADD, 0, 0, e_f((k == 0) ? 2'd0 : 2'd3, 1));
            cyc("re_add_d", 0, 32'd0, 0, 0, e_d((k == 0) ? 2'd0 : 2'd3));
            cyc("re_add_e", 0, 32'd0, 0, 0, e_ex(2'd3, 0, 2'd2, 0, 0));
            cyc("re_add_w", 0, 32'd0, 0, 0, e_wb(2'd3));
        end
`ifdef CTRL_PERF_CNT_EN
        chk("instret_cnt", instret_cnt, 32'd3);
        chk("cycle_cnt",   cycle_cnt,   32'd12);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
